// File: rtl/io_port.sv
// io_port: CPU-side byte I/O responder with an output FIFO and a one-byte input holding register
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   iow_i        CPU write strobe; ioout_i is queued into the output FIFO
//   ioout_i      CPU write data
//   ior_i        CPU read strobe; releases the input holding register
//   ioin_o       last byte captured from the device
//   out_data_o   FIFO head byte to the device
//   out_valid_o  FIFO non-empty
//   out_ready_i  device accepts out_data_o this cycle
//   in_data_i    device byte
//   in_valid_i   device offers in_data_i
//   in_ready_o   holding register can accept a byte
//   clrflags_i   clears the sticky ovf/udf flags
//   status_o     {ovf, udf, 3'b0, in_full, out_full, out_empty}
//   irq_o        interrupt request, registered; constant 0 unless IO_PORT_IRQ_EN is defined
//
// Build option: define IO_PORT_IRQ_EN to enable the registered irq_o output.
module io_port #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iow_i,
    input  logic [WIDTH-1:0] ioout_i,
    input  logic             ior_i,
    output logic [WIDTH-1:0] ioin_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             clrflags_i,
    output logic [7:0]       status_o,
    output logic             irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ioin_q, ioin_d;
    logic             in_full_q, in_full_d;
    logic             rdy_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             out_empty, out_full, push, pop, capture, release_in;

    always_comb begin
        out_empty  = cnt_q == '0;
        out_full   = cnt_q == CW'(DEPTH);
        pop        = ~out_empty & out_ready_i;
        push       = iow_i & (~out_full | pop);
        capture    = in_valid_i & in_ready_o;
        release_in = ior_i & in_full_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d      = (push & ~pop) ? cnt_q + CW'(1) : (pop & ~push) ? cnt_q - CW'(1) : cnt_q;
        ioin_d     = capture ? in_data_i : ioin_q;
        in_full_d  = capture | (in_full_q & ~release_in);
        // A new event in the same cycle as clrflags wins over the clear
        ovf_d      = (iow_i & ~push) | (ovf_q & ~clrflags_i);
        udf_d      = (ior_i & ~in_full_q) | (udf_q & ~clrflags_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ioin_q    <= '0;
            in_full_q <= 1'b0;
            rdy_q     <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= ioout_i;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ioin_q    <= ioin_d;
            in_full_q <= in_full_d;
            rdy_q     <= 1'b1;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_valid_o = ~out_empty;
    assign ioin_o      = ioin_q;
    // rdy_q holds the input side off until the first edge after reset release
    assign in_ready_o  = rdy_q & ~in_full_q;
    assign status_o    = {ovf_q, udf_q, 3'b0, in_full_q, out_full, out_empty};

`ifdef IO_PORT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= in_full_q | ovf_q;
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule
